// File: rtl/alu_issue_ctrl.sv
// Registered issue/capture front end for the single-cycle combinational ALU.
// Optional reference-model cross-check is enabled with `define ALU_SELFCHECK_EN.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [CTL_W-1:0] req_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
`ifdef ALU_SELFCHECK_EN
  output logic             rsp_mismatch,
`endif
  output logic [15:0]      op_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_n;
  logic             err_q, err_n;
  logic             req_ready_n;
  logic [WIDTH-1:0] alu_a_n, alu_b_n, rsp_result_n;
  logic [CTL_W-1:0] alu_ctl_n;
  logic             rsp_valid_n, rsp_zero_n, rsp_err_n;
  logic [CNT_W-1:0] op_count_n;

  function automatic logic ctl_legal(input logic [CTL_W-1:0] c);
    case (c)
      CTL_W'(4'b0000), CTL_W'(4'b0001), CTL_W'(4'b0010),
      CTL_W'(4'b0110), CTL_W'(4'b0111), CTL_W'(4'b1100): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

`ifdef ALU_SELFCHECK_EN
  logic [WIDTH-1:0] model_result;
  logic             rsp_mismatch_n;

  // Golden ALU evaluated on the registered operands.
  always_comb begin
    model_result = '0;
    case (alu_ctl)
      CTL_W'(4'b0000): model_result = alu_a & alu_b;
      CTL_W'(4'b0001): model_result = alu_a | alu_b;
      CTL_W'(4'b0010): model_result = alu_a + alu_b;
      CTL_W'(4'b0110): model_result = alu_a - alu_b;
      CTL_W'(4'b0111): model_result = ($signed(alu_a) < $signed(alu_b)) ? WIDTH'(1) : '0;
      CTL_W'(4'b1100): model_result = ~(alu_a | alu_b);
      default:         model_result = '0;
    endcase
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    err_n        = err_q;
    alu_a_n      = alu_a;
    alu_b_n      = alu_b;
    alu_ctl_n    = alu_ctl;
    rsp_valid_n  = rsp_valid;
    rsp_result_n = rsp_result;
    rsp_zero_n   = rsp_zero;
    rsp_err_n    = rsp_err;
    op_count_n   = op_count;
`ifdef ALU_SELFCHECK_EN
    rsp_mismatch_n = rsp_mismatch;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          alu_a_n   = req_a;
          alu_b_n   = req_b;
          alu_ctl_n = req_ctl;
          err_n     = ~ctl_legal(req_ctl);
          state_n   = EXEC;
        end
      end
      EXEC: begin
        rsp_result_n = alu_result;
        rsp_zero_n   = alu_zero;
        rsp_err_n    = err_q;
        rsp_valid_n  = 1'b1;
`ifdef ALU_SELFCHECK_EN
        rsp_mismatch_n = (alu_result != model_result) ||
                         (alu_zero != (model_result == '0));
`endif
        state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          op_count_n  = op_count + CNT_W'(1);
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Requests are only taken in IDLE, so ready tracks the upcoming state.
    req_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctl    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
`ifdef ALU_SELFCHECK_EN
      rsp_mismatch <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      err_q      <= err_n;
      req_ready  <= req_ready_n;
      alu_a      <= alu_a_n;
      alu_b      <= alu_b_n;
      alu_ctl    <= alu_ctl_n;
      rsp_valid  <= rsp_valid_n;
      rsp_result <= rsp_result_n;
      rsp_zero   <= rsp_zero_n;
      rsp_err    <= rsp_err_n;
      op_count   <= op_count_n;
`ifdef ALU_SELFCHECK_EN
      rsp_mismatch <= rsp_mismatch_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: table-driven operations with a response scoreboard,
// plus hand-written back-pressure, reset-mid-op and optional self-check sequences.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  req_ctl, alu_ctl;
  logic        alu_zero, rsp_zero, rsp_err;
  logic [15:0] op_count;
`ifdef ALU_SELFCHECK_EN
  logic        rsp_mismatch;
`endif

  logic        force_en;
  logic [31:0] force_val;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic        mm;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .CTL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
`ifdef ALU_SELFCHECK_EN
    .rsp_mismatch(rsp_mismatch),
`endif
    .op_count(op_count)
  );

  // Stand-in combinational ALU driven by the registered operands.
  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
    if (force_en) alu_result = force_val;
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Offer one request; returns after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                       input exp_t e);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_ctl   = ctl;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_ctl", {28'd0, alu_ctl}, {28'd0, ctl});
    chk("exec_ready_low", {31'd0, req_ready}, 32'd0);
    chk("exec_no_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  // Wait for a response, score it, complete the handshake.
  task automatic collect();
    int w = 0;
    exp_t e;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
`ifdef ALU_SELFCHECK_EN
      chk("rsp_mismatch", {31'd0, rsp_mismatch}, {31'd0, e.mm});
`endif
    end
    chk("resp_ready_low", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
    chk("op_count", {16'd0, op_count}, exp_count);
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                        input exp_t e);
    issue(a, b, ctl, e);
    @(negedge clk);
    chk("latency_valid", {31'd0, rsp_valid}, 32'd1);
    collect();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0]  = '{32'h00000001, 32'h00000002, 4'b0010, 32'h00000003, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000001, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{32'h00000005, 32'h00000003, 4'b0110, 32'h00000002, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFF0000, 32'h0F0F0F0F, 4'b0000, 32'h0F0F0000, 1'b0, 1'b0};
    vecs[7]  = '{32'h000000F0, 32'h0000000F, 4'b0001, 32'h000000FF, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h00000000, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'hAAAA5555, 32'h12345678, 4'b1111, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{32'h00000007, 32'h00000009, 4'b0011, 32'h00000000, 1'b1, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_ctl = '0;
    force_en = 1'b0; force_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      e = '{vecs[i].res, vecs[i].zero, vecs[i].err, 1'b0};
      run_op(vecs[i].a, vecs[i].b, vecs[i].ctl, e);
    end

    // Back-pressure with a competing request held on the input.
    issue(32'd7, 32'd8, 4'b0010, '{32'd15, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd3; req_ctl = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'd15);
      chk("bp_zero", {31'd0, rsp_zero}, 32'd0);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_alu_a", alu_a, 32'd7);
      @(negedge clk);
    end
    collect();
    chk("bp_not_taken", alu_a, 32'd7);
    sb.push_back('{32'd2, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_taken_a", alu_a, 32'd5);
    chk("bp_taken_ctl", {28'd0, alu_ctl}, 32'd6);
    @(negedge clk);
    chk("bp_latency", {31'd0, rsp_valid}, 32'd1);
    collect();

    // Reset while the SUB is in EXEC.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd3; req_ctl = 4'b0110;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_exec_a", alu_a, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("mid_rst_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_ready", {31'd0, req_ready}, 32'd1);
    end
    run_op(32'd10, 32'd4, 4'b0110, '{32'd6, 1'b0, 1'b0, 1'b0});

`ifdef ALU_SELFCHECK_EN
    force_en = 1'b1; force_val = 32'h1;
    run_op(32'hFFFF0000, 32'h0F0F0F0F, 4'b0000, '{32'h1, 1'b0, 1'b0, 1'b1});
    force_en = 1'b0;
    run_op(32'h0, 32'h0, 4'b1100, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
